// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input and RAM write / control outputs of the
// program loader. The slave modport is the loader itself; master is the
// side that feeds bytes and observes the RAM port.
interface prog_loader_if;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        ram_load;
   logic [1:0]  ram_wr;
   logic [15:0] ram_addr;
   logic [63:0] ram_d;
   logic        run;
   logic        busy;
   logic        err;

   modport master (
      output in_valid, in_data,
      input  in_ready, ram_load, ram_wr, ram_addr, ram_d, run, busy, err
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, ram_load, ram_wr, ram_addr, ram_d, run, busy, err
   );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: receives a program image over a byte stream
// (2-byte little-endian word count N, then N little-endian 64-bit words),
// writes each word into CPU RAM, then pulses run for one cycle.
// Optional trailing checksum byte enabled by defining LOADER_CSUM_EN:
// the 8-bit sum of all data bytes must match, else err is set and run is
// suppressed. Without the macro, err is tied low.
module prog_loader #(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter logic [15:0] ADDR_STEP = 16'd1
) (
   input  logic           clk,
   input  logic           rst_n,
   prog_loader_if.slave   bus
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LEN1  = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_CSUM  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   // State entered once all words are written (or N=0)
`ifdef LOADER_CSUM_EN
   localparam logic [2:0] S_FINAL = S_CSUM;
`else
   localparam logic [2:0] S_FINAL = S_DONE;
`endif

   logic [2:0]  state_q, state_d;
   logic        ready_q, ready_d;
   logic [15:0] len_q, len_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wcnt_q, wcnt_d;
   logic [2:0]  bcnt_q, bcnt_d;
   logic [63:0] shift_q, shift_d;
   logic [15:0] wcnt_inc;
   logic [15:0] len_full;
   logic        accept;

`ifdef LOADER_CSUM_EN
   logic [7:0]  csum_q, csum_d;
   logic        err_q, err_d;
`endif

   assign accept   = bus.in_valid && ready_q;
   assign wcnt_inc = wcnt_q + 16'd1;
   assign len_full = {bus.in_data, len_q[7:0]};

   // Next-state and datapath update for the load sequence
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      addr_d  = addr_q;
      wcnt_d  = wcnt_q;
      bcnt_d  = bcnt_q;
      shift_d = shift_q;
`ifdef LOADER_CSUM_EN
      csum_d  = csum_q;
      err_d   = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               len_d   = {8'h00, bus.in_data};
`ifdef LOADER_CSUM_EN
               csum_d  = 8'h00;
               err_d   = 1'b0;
`endif
               state_d = S_LEN1;
            end
         end
         S_LEN1: begin
            if (accept) begin
               len_d = len_full;
               if (len_full == 16'h0000) begin
                  state_d = S_FINAL;
               end else begin
                  state_d = S_DATA;
                  addr_d  = BASE_ADDR;
                  wcnt_d  = 16'h0000;
                  bcnt_d  = 3'd0;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               // Shift right so the first byte ends up in bits [7:0]
               shift_d = {bus.in_data, shift_q[63:8]};
`ifdef LOADER_CSUM_EN
               csum_d  = csum_q + bus.in_data;
`endif
               bcnt_d  = bcnt_q + 3'd1;
               if (bcnt_q == 3'd7) state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            addr_d = addr_q + ADDR_STEP;
            wcnt_d = wcnt_inc;
            state_d = (wcnt_inc == len_q) ? S_FINAL : S_DATA;
         end
`ifdef LOADER_CSUM_EN
         S_CSUM: begin
            if (accept) begin
               if (bus.in_data == csum_q) begin
                  state_d = S_DONE;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Ready is registered so it is low while reset is asserted
      ready_d = (state_d == S_IDLE) || (state_d == S_LEN1) ||
                (state_d == S_DATA) || (state_d == S_CSUM);
   end

   // Main loader registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ready_q <= 1'b0;
         len_q   <= 16'h0000;
         addr_q  <= BASE_ADDR;
         wcnt_q  <= 16'h0000;
         bcnt_q  <= 3'd0;
         shift_q <= 64'h0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         len_q   <= len_d;
         addr_q  <= addr_d;
         wcnt_q  <= wcnt_d;
         bcnt_q  <= bcnt_d;
         shift_q <= shift_d;
      end
   end

`ifdef LOADER_CSUM_EN
   // Checksum accumulator and sticky error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum_q <= 8'h00;
         err_q  <= 1'b0;
      end else begin
         csum_q <= csum_d;
         err_q  <= err_d;
      end
   end
   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.in_ready = ready_q;
   assign bus.ram_load = (state_q == S_WRITE);
   assign bus.ram_wr   = (state_q == S_WRITE) ? 2'b11 : 2'b00;
   assign bus.ram_addr = addr_q;
   assign bus.ram_d    = shift_q;
   assign bus.run      = (state_q == S_DONE);
   assign bus.busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed streams into two loaders sharing one byte
// stream, one with BASE_ADDR=0000 and one with BASE_ADDR=FFFF.
module tb_prog_loader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       v = 1'b0;
   logic [7:0] d = 8'h00;

   always #5 clk = ~clk;

   prog_loader_if bus0();
   prog_loader_if bus1();

   assign bus0.in_valid = v;
   assign bus0.in_data  = d;
   assign bus1.in_valid = v;
   assign bus1.in_data  = d;

   prog_loader #(.BASE_ADDR(16'h0000), .ADDR_STEP(16'd1)) u0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
   );
   prog_loader #(.BASE_ADDR(16'hFFFF), .ADDR_STEP(16'd1)) u1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
   );

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   logic [7:0] csum_acc = 8'h00;

   logic [15:0] la0[$];
   logic [15:0] la1[$];
   logic [63:0] ld0[$];
   int          lc[$];
   int nrun = 0, nrun1 = 0, run_cyc = 0, viol = 0, rlow = 0, bad_wr = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Observe RAM writes, run pulses and ready behaviour once per cycle
   always @(negedge clk) begin
      if (bus0.ram_load === 1'b1) begin
         la0.push_back(bus0.ram_addr);
         ld0.push_back(bus0.ram_d);
         lc.push_back(cyc);
         if (bus0.ram_wr !== 2'b11) bad_wr++;
      end else if (rst_n && bus0.ram_wr !== 2'b00) begin
         bad_wr++;
      end
      if (bus1.ram_load === 1'b1) la1.push_back(bus1.ram_addr);
      if (bus0.run === 1'b1) begin nrun++; run_cyc = cyc; end
      if (bus1.run === 1'b1) nrun1++;
      if (bus0.busy === 1'b1 && (bus0.in_ready !== !(bus0.ram_load || bus0.run))) viol++;
      if (bus0.busy === 1'b1 && bus0.in_ready === 1'b0 && bus0.run === 1'b0) rlow++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Present one byte and hold it until accepted (bounded)
   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      v = 1'b1;
      d = b;
      while (bus0.in_ready !== 1'b1 && t < 40) begin
         @(negedge clk);
         t++;
      end
      check("byte_accept_ready", {63'd0, bus0.in_ready}, 64'd1);
      @(negedge clk);
      v = 1'b0;
   endtask

   task automatic gap_cycle(input bit gap);
      if (gap) @(negedge clk);
   endtask

   task automatic send_len(input logic [15:0] n, input bit gap);
      csum_acc = 8'h00;
      send_byte(n[7:0]);
      gap_cycle(gap);
      send_byte(n[15:8]);
      gap_cycle(gap);
   endtask

   task automatic send_word(input logic [63:0] w, input bit gap);
      for (int k = 0; k < 8; k++) begin
         send_byte(w[8*k +: 8]);
         csum_acc = csum_acc + w[8*k +: 8];
         gap_cycle(gap);
      end
   endtask

   task automatic end_stream();
`ifdef LOADER_CSUM_EN
      send_byte(csum_acc);
`endif
   endtask

   task automatic wait_idle(input string tag);
      int t = 0;
      while (bus0.busy === 1'b1 && t < 60) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      check(tag, {63'd0, bus0.busy}, 64'd0);
   endtask

   int s0, r0, r1, vi0, rl0, last;
`ifdef LOADER_CSUM_EN
   localparam int RUN_LAT = 2;
`else
   localparam int RUN_LAT = 1;
`endif

   initial begin
      // ---------------- reset values ----------------
      #1 rst_n = 1'b0;
      #11;
      check("rst_in_ready",  {63'd0, bus0.in_ready}, 64'd0);
      check("rst_busy",      {63'd0, bus0.busy},     64'd0);
      check("rst_ram_load",  {63'd0, bus0.ram_load}, 64'd0);
      check("rst_ram_wr",    {62'd0, bus0.ram_wr},   64'd0);
      check("rst_addr0",     {48'd0, bus0.ram_addr}, 64'h0000);
      check("rst_addr1",     {48'd0, bus1.ram_addr}, 64'hFFFF);
      check("rst_ram_d",     bus0.ram_d,             64'd0);
      check("rst_run",       {63'd0, bus0.run},      64'd0);
      check("rst_err",       {63'd0, bus0.err},      64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("idle_in_ready", {63'd0, bus0.in_ready}, 64'd1);

      // ---------------- N=1 single word ----------------
      s0 = la0.size(); r0 = nrun;
      send_len(16'd1, 1'b0);
      send_word(64'h0000_0000_0000_0102, 1'b0);
      end_stream();
      wait_idle("n1_idle");
      check("n1_loads",   64'(la0.size() - s0), 64'd1);
      check("n1_addr0",   {48'd0, la0[s0]}, 64'h0000);
      check("n1_addr1",   {48'd0, la1[s0]}, 64'hFFFF);
      check("n1_data",    ld0[s0], 64'h0000_0000_0000_0102);
      check("n1_runs",    64'(nrun - r0), 64'd1);
      check("n1_run_lat", 64'(run_cyc - lc[s0]), 64'(RUN_LAT));
      check("n1_err",     {63'd0, bus0.err}, 64'd0);

`ifdef LOADER_CSUM_EN
      // ---------------- bad checksum, then clear with empty image ----
      s0 = la0.size(); r0 = nrun;
      send_len(16'd1, 1'b0);
      send_word(64'h0000_0000_0000_0102, 1'b0);
      send_byte(8'h04);
      wait_idle("bad_idle");
      check("bad_loads",  64'(la0.size() - s0), 64'd1);
      check("bad_data",   ld0[s0], 64'h0000_0000_0000_0102);
      check("bad_err",    {63'd0, bus0.err}, 64'd1);
      check("bad_no_run", 64'(nrun - r0), 64'd0);
      repeat (5) @(negedge clk);
      check("bad_err_sticky", {63'd0, bus0.err}, 64'd1);
      send_byte(8'h00);
      check("err_cleared", {63'd0, bus0.err}, 64'd0);
      send_byte(8'h00);
      send_byte(8'h00);
      wait_idle("clr_idle");
      check("clr_runs",  64'(nrun - r0), 64'd1);
      check("clr_loads", 64'(la0.size() - s0), 64'd1);
`endif

      // ---------------- N=3 with address wrap on u1 ----------------
      s0 = la0.size(); r0 = nrun; r1 = nrun1;
      send_len(16'd3, 1'b0);
      send_word(64'h1122_3344_5566_7788, 1'b0);
      send_word(64'h0123_4567_89AB_CDEF, 1'b0);
      send_word(64'hFEDC_BA98_7654_3210, 1'b0);
      end_stream();
      wait_idle("n3_idle");
      check("n3_loads",  64'(la0.size() - s0), 64'd3);
      check("n3_a1_0",   {48'd0, la1[s0]},     64'hFFFF);
      check("n3_a1_1",   {48'd0, la1[s0 + 1]}, 64'h0000);
      check("n3_a1_2",   {48'd0, la1[s0 + 2]}, 64'h0001);
      check("n3_a0_2",   {48'd0, la0[s0 + 2]}, 64'h0002);
      check("n3_d0",     ld0[s0],     64'h1122_3344_5566_7788);
      check("n3_d1",     ld0[s0 + 1], 64'h0123_4567_89AB_CDEF);
      check("n3_d2",     ld0[s0 + 2], 64'hFEDC_BA98_7654_3210);
      check("n3_runs",   64'(nrun1 - r1), 64'd1);
      check("n3_run_lat", 64'(run_cyc - lc[s0 + 2]), 64'(RUN_LAT));
      check("n3_b2b_wr", 64'(lc[s0 + 1] - lc[s0]), 64'd9);

      // ---------------- N=2 with in_valid toggling ----------------
      s0 = la0.size(); r0 = nrun; vi0 = viol; rl0 = rlow;
      send_len(16'd2, 1'b1);
      send_word(64'h1122_3344_5566_7788, 1'b1);
      send_word(64'h0123_4567_89AB_CDEF, 1'b1);
      end_stream();
      wait_idle("gap_idle");
      check("gap_loads",  64'(la0.size() - s0), 64'd2);
      check("gap_a0_0",   {48'd0, la0[s0]},     64'h0000);
      check("gap_a0_1",   {48'd0, la0[s0 + 1]}, 64'h0001);
      check("gap_a1_1",   {48'd0, la1[s0 + 1]}, 64'h0000);
      check("gap_d0",     ld0[s0],     64'h1122_3344_5566_7788);
      check("gap_d1",     ld0[s0 + 1], 64'h0123_4567_89AB_CDEF);
      check("gap_runs",   64'(nrun - r0), 64'd1);
      check("gap_ready_rule", 64'(viol - vi0), 64'd0);
      check("gap_ready_low",  64'(rlow - rl0), 64'd2);

      // ---------------- reset mid-load ----------------
      s0 = la0.size(); r0 = nrun;
      send_len(16'd1, 1'b0);
      for (int k = 0; k < 5; k++) send_byte(8'h10 + 8'(k));
      rst_n = 1'b0;
      #1;
      check("mid_in_ready", {63'd0, bus0.in_ready}, 64'd0);
      check("mid_busy",     {63'd0, bus0.busy},     64'd0);
      check("mid_load",     {63'd0, bus0.ram_load}, 64'd0);
      check("mid_addr1",    {48'd0, bus1.ram_addr}, 64'hFFFF);
      check("mid_ram_d",    bus0.ram_d,             64'd0);
      check("mid_run",      {63'd0, bus0.run},      64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_no_load", 64'(la0.size() - s0), 64'd0);
      check("mid_no_run",  64'(nrun - r0), 64'd0);
      send_len(16'd1, 1'b0);
      send_word(64'hA5A5_0000_1234_5678, 1'b0);
      end_stream();
      wait_idle("fresh_idle");
      check("fresh_loads", 64'(la0.size() - s0), 64'd1);
      check("fresh_addr0", {48'd0, la0[s0]}, 64'h0000);
      check("fresh_data",  ld0[s0], 64'hA5A5_0000_1234_5678);
      check("fresh_runs",  64'(nrun - r0), 64'd1);

      // ---------------- N=0 image ----------------
      s0 = la0.size(); r0 = nrun;
      last = cyc;
      send_len(16'd0, 1'b0);
      end_stream();
      wait_idle("n0_idle");
      check("n0_no_load", 64'(la0.size() - s0), 64'd0);
      check("n0_runs",    64'(nrun - r0), 64'd1);
      check("n0_run_after_start", 64'(run_cyc > last), 64'd1);

      check("ram_wr_rule", 64'(bad_wr), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   // Absolute guard against a hung run
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
